// File: rtl/open_list_manager.sv
// open_list_manager
//
// A* OPEN-list store. It accepts up to NUM_IN new nodes per beat, keeps them
// in a DEPTH-entry register array, and always presents the lowest-f-cost node
// on a valid/ready pop port.
//
// Optional feature: define OPEN_DEDUP_EN to enable decrease-key merging of
// duplicate node IDs. The default build stores duplicates as separate entries.
//
// Parameters
//   DEPTH   number of OPEN entries (must be >= NUM_IN)
//   NUM_IN  insert lanes per beat
//   ID_W    node identifier width
//   COST_W  unsigned f-cost width
//
// Ports
//   clk       clock; all state changes on the rising edge
//   rst       asynchronous active-low reset
//   flush     synchronous clear of all entries; overrides insert and pop
//   in_valid  per-lane insert valid            [NUM_IN]
//   in_id     lane k at [k*ID_W +: ID_W]
//   in_cost   lane k at [k*COST_W +: COST_W]
//   in_ready  high when the whole beat can be accepted
//   out_valid out_id/out_cost hold the current minimum
//   out_id    ID of the minimum node
//   out_cost  f-cost of the minimum node
//   out_ready pop request
//   count     number of valid entries
//
// Handshakes: a beat transfers on a rising edge where (|in_valid && in_ready),
// and a pop transfers on a rising edge where (out_valid && out_ready). Both
// ready signals come from registered state only. out_* may change while
// out_valid is high without a handshake (e.g. a cheaper node arrives), so the
// consumer samples them only on the pop edge. flush drops both transfers.

module open_list_manager #(
  parameter int DEPTH  = 64,
  parameter int NUM_IN = 8,
  parameter int ID_W   = 16,
  parameter int COST_W = 16,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic [NUM_IN*ID_W-1:0]   in_id,
  input  logic [NUM_IN*COST_W-1:0] in_cost,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [ID_W-1:0]          out_id,
  output logic [COST_W-1:0]        out_cost,
  input  logic                     out_ready,
  output logic [CW-1:0]            count
);

  // Registered state
  logic [DEPTH-1:0]  vld_q;
  logic [ID_W-1:0]   id_q   [DEPTH];
  logic [COST_W-1:0] cost_q [DEPTH];
  logic              min_vld_q;
  logic [IW-1:0]     min_idx_q;
  logic [ID_W-1:0]   min_id_q;
  logic [COST_W-1:0] min_cost_q;
  logic [CW-1:0]     count_q;

  // Next state
  logic [DEPTH-1:0]  vld_d;
  logic [ID_W-1:0]   id_d   [DEPTH];
  logic [COST_W-1:0] cost_d [DEPTH];
  logic              min_vld_d;
  logic [IW-1:0]     min_idx_d;
  logic [ID_W-1:0]   min_id_d;
  logic [COST_W-1:0] min_cost_d;
  logic [CW-1:0]     count_d;

  // Working variables of the update process
  logic              accept;
  logic              pop;
  logic [CW-1:0]     ins_cnt;
  logic [DEPTH-1:0]  free_v;
  logic              lane_wr;
  logic              slot_found;
  logic [ID_W-1:0]   lane_id;
  logic [COST_W-1:0] lane_cost;

  // Free space is judged on registered count only, so a slot released by a
  // pop this cycle does not open the door until the next cycle.
  assign in_ready = (DEPTH - int'(count_q)) >= NUM_IN;
  assign accept   = (|in_valid) && in_ready && !flush;
  assign pop      = min_vld_q && out_ready && !flush;

  assign out_valid = min_vld_q;
  assign out_id    = min_id_q;
  assign out_cost  = min_cost_q;
  assign count     = count_q;

  // Entry update: pop, then lane writes into the lowest free indices.
  always_comb begin
    vld_d      = vld_q;
    id_d       = id_q;
    cost_d     = cost_q;
    ins_cnt    = '0;
    free_v     = ~vld_q;   // the popped entry is deliberately not reusable yet
    lane_wr    = 1'b0;
    slot_found = 1'b0;
    lane_id    = '0;
    lane_cost  = '0;

    if (pop) vld_d[min_idx_q] = 1'b0;

    for (int k = 0; k < NUM_IN; k++) begin
      lane_id   = in_id[k*ID_W +: ID_W];
      lane_cost = in_cost[k*COST_W +: COST_W];
      lane_wr   = accept && in_valid[k];
`ifdef OPEN_DEDUP_EN
      // Among lanes carrying the same ID, only the cheapest (lowest lane on a
      // tie) survives.
      for (int j = 0; j < NUM_IN; j++) begin
        if (j != k && in_valid[j] && in_id[j*ID_W +: ID_W] == lane_id &&
            (in_cost[j*COST_W +: COST_W] < lane_cost ||
             (in_cost[j*COST_W +: COST_W] == lane_cost && j < k)))
          lane_wr = 1'b0;
      end
      // A surviving lane that hits a held entry never takes a slot; it only
      // lowers the entry cost. The entry leaving by pop this cycle is not a
      // hit, so such a lane is stored as a fresh node.
      if (lane_wr) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (vld_q[i] && !(pop && min_idx_q == IW'(i)) && id_q[i] == lane_id) begin
            lane_wr = 1'b0;
            if (lane_cost < cost_q[i]) cost_d[i] = lane_cost;
          end
        end
      end
`endif
      if (lane_wr) begin
        slot_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
          if (!slot_found && free_v[i]) begin
            free_v[i]  = 1'b0;
            vld_d[i]   = 1'b1;
            id_d[i]    = lane_id;
            cost_d[i]  = lane_cost;
            slot_found = 1'b1;
          end
        end
        ins_cnt = ins_cnt + CW'(1);
      end
    end

    if (flush) vld_d = '0;
  end

  assign count_d = flush ? '0 : (count_q + ins_cnt - {{(CW-1){1'b0}}, pop});

  // Argmin over the post-update contents; strict compare keeps the lowest
  // index on equal cost.
  always_comb begin
    min_vld_d  = 1'b0;
    min_idx_d  = '0;
    min_id_d   = '0;
    min_cost_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_d[i] && (!min_vld_d || cost_d[i] < min_cost_d)) begin
        min_vld_d  = 1'b1;
        min_idx_d  = IW'(i);
        min_id_d   = id_d[i];
        min_cost_d = cost_d[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        id_q[i]   <= '0;
        cost_q[i] <= '0;
      end
      min_vld_q  <= 1'b0;
      min_idx_q  <= '0;
      min_id_q   <= '0;
      min_cost_q <= '0;
      count_q    <= '0;
    end else begin
      vld_q      <= vld_d;
      for (int i = 0; i < DEPTH; i++) begin
        id_q[i]   <= id_d[i];
        cost_q[i] <= cost_d[i];
      end
      min_vld_q  <= min_vld_d;
      min_idx_q  <= min_idx_d;
      min_id_q   <= min_id_d;
      min_cost_q <= min_cost_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: doc/open_list_manager.md
# open_list_manager

Parametrised A* OPEN-list store: accepts up to `NUM_IN` newly generated nodes per cycle from the expansion stage, holds them in a `DEPTH`-entry register array, and continuously presents the lowest-f-cost node to the expansion stage through a valid/ready pop port. It is a drop-in successor to the single-shot node manager. It adds the following:
- Backpressure on insertion.
- Removal on pop.
- Occupancy reporting and flush.
- Optional decrease-key merging of duplicate node IDs.

## Interface
- `DEPTH`, 64: number of OPEN entries. Must be ≥ `NUM_IN`.
- `NUM_IN`, 8: insert lanes per beat.
- `ID_W`, 16: node identifier width (packed grid coordinate).
- `COST_W`, 16: f-cost width. Costs are unsigned.

- `clk`, in, 1: sole clock. All state changes on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset. Assertion is immediate; deassertion is synchronous to `clk` upstream.
- `flush`, in, 1: synchronous clear of all entries.
- `in_valid`, in, `NUM_IN`: per-lane insert valid.
- `in_id`, in, `NUM_IN*ID_W`: lane *k* occupies bits [k*ID_W +: ID_W].
- `in_cost`, in, `NUM_IN*COST_W`: lane *k* f-cost.
- `in_ready`, out, 1: the whole beat is accepted when high.
- `out_valid`, out, 1: `out_id`/`out_cost` hold the current minimum.
- `out_id`, out, `ID_W`: ID of the minimum node.
- `out_cost`, out, `COST_W`: f-cost of the minimum node.
- `out_ready`, in, 1: pop request.
- `count`, out, `$clog2(DEPTH+1)`: number of valid entries.

## Operation
**State**
- Per entry: `vld`, `id`, `cost`.
- Registered min: `min_vld`, `min_idx`, `min_id`, `min_cost`.
- `count` register.

**Insert**
- A beat is accepted when `|in_valid && in_ready`.
- `in_ready` = (`DEPTH` − `count`) ≥ `NUM_IN`, taken from registered state. All-or-nothing: no partial beats.
- Valid lanes are written in ascending lane order to ascending free indices (lowest free index first). Invalid lanes consume no slot.

**Min search**
- Each cycle, a combinational argmin runs over the valid entries **after** this cycle's updates are applied. The result is registered into `min_*`.
- Tie on cost: lowest index wins.

**Pop**
- `out_valid && out_ready`: clears `vld[min_idx]` and decrements `count`.
- The entry freed by a pop is not visible as free to `in_ready` until the next cycle.

**Output contract**
- `out_*` reflects the list contents as of the previous edge. It may change while `out_valid` is high without a handshake, for example when a cheaper node is inserted.
- The consumer samples `out_*` on the handshake edge only.

**Simultaneous events**
- Insert and pop in the same cycle: both take effect. `count` += inserted − 1.
- The popped entry is excluded from the next min.
- `flush` overrides both insert and pop. The beat is dropped; all entries are cleared; `count` becomes 0.

**Empty**
- `out_valid` = 0. `out_ready` is ignored; no underflow.

**Full**
- `in_ready` = 0. The producer must hold the beat.

## Timing
- Reset values (`rst` low):
  - All `vld` = 0, `count` = 0.
  - `out_valid` = 0, `out_id` = 0, `out_cost` = 0.
  - `in_ready` = 1.
- Insert-to-visible latency: 1 cycle. A node accepted at edge N can be `out_*` after edge N. `count` updates at edge N.
- Pop-to-next-min latency: 1 cycle. The next minimum is presented after the pop edge, so back-to-back pops are sustained at 1 per cycle.
- Reset asserted mid-operation: all state clears immediately. Any in-flight beat or pop is lost.
- Throughput: `NUM_IN` inserts plus 1 pop per cycle.

## Configuration
- `OPEN_DEDUP_EN` defined: decrease-key merging is enabled.
  - Each valid lane's `id` is compared against all valid entries.
  - On a match with `in_cost` < entry cost, the entry's cost is overwritten in place. On a match with `in_cost` ≥ entry cost, the lane is discarded.
  - A matched lane consumes no slot.
  - Equal IDs on several lanes in one beat: keep the lowest cost; on equal cost, keep the lowest lane. The others are discarded.
  - A match against the entry being popped in the same cycle is treated as a new insert.
  - `in_ready` is unchanged: conservative, no match credit.
- `OPEN_DEDUP_EN` undefined: no ID comparison. Duplicates occupy separate entries.

## Test plan
Test configuration: `DEPTH`=8, `NUM_IN`=4.

- **Reset:** hold `rst` low for 3 cycles, then release. Require `out_valid`=0, `count`=0, `in_ready`=1. Pop with `out_ready`=1 while empty: `count` stays 0.
- **Ordering:** one beat with ids 1–4 and costs 30, 10, 20, 10. Next cycle: `out_id`=2, `out_cost`=10, `count`=4. Continuous pops return ids 2, 4, 3, 1 on consecutive cycles, then `out_valid`=0.
- **Full and backpressure:** two full beats give `count`=8 and `in_ready`=0. Hold a third beat. Pop once: `in_ready` stays 0 (4 free needed). After 4 pops, the held beat is accepted on the next edge.
- **Simultaneous insert and pop:** `count`=3 with min cost 5. Insert costs 2 and 9 while popping the cost-5 node. Next cycle: `count`=4, `out_cost`=2.
- **Flush:** `flush`=1 with insert and pop asserted. Next cycle: `count`=0, `out_valid`=0, and the beat is not stored.
- **Decrease-key (`OPEN_DEDUP_EN` only):** id 7 already held at cost 40. Insert id 7 at cost 15: `count` unchanged, `out_cost`=15. Then insert id 7 at cost 50: discarded, cost stays 15.
